// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: packs instruction fields into 32-bit ISA words,
// buffers them in a small FIFO and writes them to instruction memory at
// consecutive word addresses for the boot/test loader.
// Optional build macro: ENCODER_CHECKSUM_EN adds a running 32-bit sum of all
// written words on the 'checksum' output.
module instr_encoder_loader #(
    parameter int unsigned ADDR_W     = 12,
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_fmt,
    input  logic [6:0]        in_opcode,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [31:0]       in_offset,
    input  logic              in_last,
    output logic              wr_en,
    input  logic              wr_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [CNT_W-1:0]  words_written,
    output logic [CNT_W-1:0]  err_count
`ifdef ENCODER_CHECKSUM_EN
   ,output logic [31:0]       checksum
`endif
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [31:0]       mem_q [FIFO_DEPTH];
    logic [31:0]       mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]  occ_q, occ_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  words_q, words_d;
    logic [CNT_W-1:0]  errs_q, errs_d;
`ifdef ENCODER_CHECKSUM_EN
    logic [31:0]       cks_q, cks_d;
`endif

    logic signed [31:0] off_s;
    logic [31:0]        enc_word;
    logic               enc_legal;
    logic               fifo_empty;
    logic               fifo_full;
    logic               accept;
    logic               push;
    logic               pop;

    assign off_s = in_offset;

    // Encode the current beat and decide whether its offset fits the format
    always_comb begin
        enc_word  = '0;
        enc_legal = 1'b1;
        case (in_fmt)
            2'd0: enc_word = {in_opcode, in_rd, in_rs1, in_rs2, 10'd0};
            2'd1: begin
                enc_word  = {in_opcode, in_rd, in_rs1, in_offset[14:0]};
                enc_legal = (off_s >= -32'sd16384) && (off_s <= 32'sd16383);
            end
            2'd2: begin
                // Word offset w = offset>>>2 truncated to 15 bits is offset[16:2]
                enc_word  = {in_opcode, in_offset[16:12], in_rs1, in_rs2, in_offset[11:2]};
                enc_legal = (in_offset[1:0] == 2'b00) &&
                            (off_s >= -32'sd65536) && (off_s <= 32'sd65532);
            end
            default: enc_word = {in_opcode, in_offset[19:15], 5'd0, in_offset[14:0]};
        endcase
    end

    // Handshakes and output views of the registered state
    always_comb begin
        fifo_empty    = (occ_q == '0);
        fifo_full     = (occ_q == OCC_FULL);
        in_ready      = (state_q == S_RUN) && !fifo_full;
        accept        = in_valid && in_ready;
        push          = accept && enc_legal;
        wr_en         = !fifo_empty;
        pop           = wr_en && wr_ready;
        wr_data       = fifo_empty ? '0 : mem_q[rd_ptr_q];
        wr_addr       = addr_q;
        busy          = (state_q != S_IDLE);
        done          = (state_q == S_DONE);
        err           = err_q;
        words_written = words_q;
        err_count     = errs_q;
    end

`ifdef ENCODER_CHECKSUM_EN
    assign checksum = cks_q;
`endif

    // Next-state logic for the session FSM, FIFO and counters
    always_comb begin
        state_d  = state_q;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        addr_d   = addr_q;
        err_d    = err_q;
        words_d  = words_q;
        errs_d   = errs_q;
`ifdef ENCODER_CHECKSUM_EN
        cks_d    = cks_q;
`endif

        if (push) begin
            mem_d[wr_ptr_q] = enc_word;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            addr_d   = addr_q + ADDR_W'(4);
            if (words_q != '1) begin
                words_d = words_q + CNT_W'(1);
            end
`ifdef ENCODER_CHECKSUM_EN
            cks_d = cks_q + wr_data;
`endif
        end

        case ({push, pop})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase

        if (accept && !enc_legal) begin
            err_d = 1'b1;
            if (errs_q != '1) begin
                errs_d = errs_q + CNT_W'(1);
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    addr_d  = start_addr & ~ADDR_W'(3);
                    words_d = '0;
                    errs_d  = '0;
                    err_d   = 1'b0;
`ifdef ENCODER_CHECKSUM_EN
                    cks_d   = '0;
`endif
                end
            end
            S_RUN:   if (accept && in_last) state_d = S_DRAIN;
            S_DRAIN: if (fifo_empty) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Session state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FIFO storage, pointers, address and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            addr_q   <= '0;
            err_q    <= 1'b0;
            words_q  <= '0;
            errs_q   <= '0;
`ifdef ENCODER_CHECKSUM_EN
            cks_q    <= '0;
`endif
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            addr_q   <= addr_d;
            err_q    <= err_d;
            words_q  <= words_d;
            errs_q   <= errs_d;
`ifdef ENCODER_CHECKSUM_EN
            cks_q    <= cks_d;
`endif
        end
    end

endmodule
